// File: rtl/seq_reduce_pkg.sv
// Shared types for the multi-cycle reduction engine: operator encodings,
// FSM states and the per-operator fold identity.
package seq_reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // NOR folds as OR, so only AND starts from 1.
  function automatic logic op_identity(input op_e op);
    return (op == OP_AND);
  endfunction

endpackage

// File: rtl/seq_reduce_if.sv
// Request/response bundle of the reduction engine.
// Handshake: start is sampled only while the engine is idle; busy is high
// while folding; done is a single-cycle pulse and result/found/first_idx are
// valid from that cycle until the next accepted start. No backpressure.
interface seq_reduce_if
  import seq_reduce_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) ();
  logic          start;
  op_e           op;
  logic [N-1:0]  in_data;
  logic          busy;
  logic          done;
  logic          result;
  logic          found;
  logic [IW-1:0] first_idx;

  modport master (
    output start, op, in_data,
    input  busy, done, result, found, first_idx
  );

  modport slave (
    input  start, op, in_data,
    output busy, done, result, found, first_idx
  );
endinterface

// File: rtl/seq_reduce_chunk_reduce.sv
// Combinational fold of one chunk into the running accumulator, plus the
// lowest set bit of the chunk restricted to bits that belong to the operand.
module chunk_reduce
  import seq_reduce_pkg::*;
#(
  parameter int C  = 8,
  parameter int PW = (C > 1) ? $clog2(C) : 1
) (
  input  op_e           op_i,
  input  logic [C-1:0]  chunk_i,
  input  logic [C-1:0]  mask_i,
  input  logic          acc_i,
  output logic          acc_o,
  output logic          any_o,
  output logic [PW-1:0] pos_o
);

  logic [C-1:0] scan;

  always_comb begin
    acc_o = acc_i | (|chunk_i);
    case (op_i)
      OP_AND:  acc_o = acc_i & (&chunk_i);
      OP_XOR:  acc_o = acc_i ^ (^chunk_i);
      default: acc_o = acc_i | (|chunk_i);
    endcase
  end

  // Padding bits are masked so they never count as a set operand bit.
  assign scan  = chunk_i & mask_i;
  assign any_o = |scan;

  always_comb begin
    pos_o = '0;
    for (int j = C - 1; j >= 0; j--) begin
      if (scan[j]) pos_o = PW'(j);
    end
  end

endmodule

// File: rtl/seq_reduce.sv
// Multi-cycle N-bit reduction: folds C bits per clock under OR/AND/XOR/NOR
// and tracks the lowest set bit; start/busy/done handshake on the interface.
module seq_reduce
  import seq_reduce_pkg::*;
#(
  parameter int N = 32,
  parameter int C = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_reduce_if.slave bus,
  output state_e state_o
);

  localparam int K  = (N + C - 1) / C;
  localparam int IW = $clog2(N);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (C > 1) ? $clog2(C) : 1;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [K*C-1:0]  data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            fint_q, fint_d;
  logic [IW-1:0]   iint_q, iint_d;
  logic            result_q, result_d;
  logic            found_q, found_d;
  logic [IW-1:0]   fidx_q, fidx_d;

  logic [C-1:0]    chunk;
  logic [C-1:0]    mask;
  logic            fold_acc;
  logic            chunk_any;
  logic [PW-1:0]   chunk_pos;
  logic [IW-1:0]   scan_idx;

  assign chunk = data_q[int'(cnt_q)*C +: C];

  always_comb begin
    for (int j = 0; j < C; j++) begin
      mask[j] = (int'(cnt_q) * C + j) < N;
    end
  end

  chunk_reduce #(.C(C), .PW(PW)) u_chunk (
    .op_i    (op_q),
    .chunk_i (chunk),
    .mask_i  (mask),
    .acc_i   (acc_q),
    .acc_o   (fold_acc),
    .any_o   (chunk_any),
    .pos_o   (chunk_pos)
  );

  assign scan_idx = IW'(int'(cnt_q) * C + int'(chunk_pos));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    fint_d   = fint_q;
    iint_d   = iint_q;
    result_d = result_q;
    found_d  = found_q;
    fidx_d   = fidx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d        = S_RUN;
          op_d           = bus.op;
          data_d         = {(K*C){op_identity(bus.op)}};
          data_d[N-1:0]  = bus.in_data;
          cnt_d          = '0;
          acc_d          = op_identity(bus.op);
          fint_d         = 1'b0;
          iint_d         = '0;
        end
      end
      S_RUN: begin
        acc_d = fold_acc;
        if (!fint_q && chunk_any) begin
          fint_d = 1'b1;
          iint_d = scan_idx;
        end
        // Visible outputs move only here, so they never glitch mid-fold.
        if (cnt_q == CW'(K - 1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = (op_q == OP_NOR) ? ~fold_acc : fold_acc;
          found_d  = fint_q | chunk_any;
          fidx_d   = fint_q ? iint_q : (chunk_any ? scan_idx : '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_OR;
      data_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      fint_q   <= 1'b0;
      iint_q   <= '0;
      result_q <= 1'b0;
      found_q  <= 1'b0;
      fidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      fint_q   <= fint_d;
      iint_q   <= iint_d;
      result_q <= result_d;
      found_q  <= found_d;
      fidx_q   <= fidx_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.found     = found_q;
  assign bus.first_idx = fidx_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_seq_reduce.sv
// Directed bench for seq_reduce: three configurations (32/8, 10/4 padded,
// 4/4 single-chunk) driven one at a time through a shared monitor mux.
module tb_seq_reduce;
  import seq_reduce_pkg::*;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;
  int   sel;

  logic [31:0] exp_q[$];

  seq_reduce_if #(.N(32)) a_if ();
  seq_reduce_if #(.N(10)) b_if ();
  seq_reduce_if #(.N(4))  c_if ();

  state_e a_state, b_state, c_state;

  seq_reduce #(.N(32), .C(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave), .state_o(a_state));
  seq_reduce #(.N(10), .C(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave), .state_o(b_state));
  seq_reduce #(.N(4),  .C(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave), .state_o(c_state));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        mon_busy, mon_done, mon_result, mon_found;
  logic [31:0] mon_idx;
  always_comb begin
    mon_busy = a_if.busy; mon_done = a_if.done; mon_result = a_if.result;
    mon_found = a_if.found; mon_idx = 32'(a_if.first_idx);
    if (sel == 1) begin
      mon_busy = b_if.busy; mon_done = b_if.done; mon_result = b_if.result;
      mon_found = b_if.found; mon_idx = 32'(b_if.first_idx);
    end else if (sel == 2) begin
      mon_busy = c_if.busy; mon_done = c_if.done; mon_result = c_if.result;
      mon_found = c_if.found; mon_idx = 32'(c_if.first_idx);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: only the selected instance sees start
  task automatic drive(input logic st, input op_e op, input logic [31:0] d);
    a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
    a_if.op = op; b_if.op = op; c_if.op = op;
    a_if.in_data = d; b_if.in_data = d[9:0]; c_if.in_data = d[3:0];
    case (sel)
      0:       a_if.start = st;
      1:       b_if.start = st;
      default: c_if.start = st;
    endcase
  endtask

  task automatic run_op(input string tag, input int s, input int k, input op_e op,
                        input logic [31:0] d, input logic er, input logic ef,
                        input logic [31:0] ei, input bit hold, input logic [31:0] mid);
    int edges;
    int busy_n;
    logic [31:0] exp_v;
    sel = s;
    exp_q.push_back({29'(ei), ef, er});
    drive(1'b1, op, d);
    @(posedge clk); #1;
    if (hold) drive(1'b1, op, mid);
    else      drive(1'b0, op, d);
    edges = 0;
    busy_n = 0;
    while (!mon_done && edges < 40) begin
      if (mon_busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    exp_v = exp_q.pop_front();
    check({tag, "/done"},    32'(mon_done),   32'd1);
    check({tag, "/latency"}, 32'(edges),      32'(k));
    check({tag, "/busy_n"},  32'(busy_n),     32'(k));
    check({tag, "/result"},  32'(mon_result), 32'(exp_v[0]));
    check({tag, "/found"},   32'(mon_found),  32'(exp_v[1]));
    check({tag, "/idx"},     mon_idx,         32'(exp_v[31:2]));
    if (!hold) drive(1'b0, op, d);
    @(posedge clk); #1;
    check({tag, "/done_clr"}, 32'(mon_done), 32'd0);
    check({tag, "/idle"},     32'(mon_busy), 32'd0);
    drive(1'b0, op, d);
    @(posedge clk); #1;
    check({tag, "/no_requeue"}, 32'(mon_busy | mon_done), 32'd0);
    check({tag, "/held"},       32'(mon_result),           32'(exp_v[0]));
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    sel = 0;
    rst_n = 1'b0;
    drive(1'b0, OP_OR, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst/a_state", 32'(a_state), 32'(S_IDLE));
    check("rst/a_out", {a_if.busy, a_if.done, a_if.result, a_if.found, 27'(a_if.first_idx)}, 32'h0);
    check("rst/b_out", {b_if.busy, b_if.done, b_if.result, b_if.found, 28'(b_if.first_idx)}, 32'h0);
    check("rst/c_out", {c_if.busy, c_if.done, c_if.result, c_if.found, 28'(c_if.first_idx)}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=32, C=8, K=4
    run_op("or_bit16",   0, 4, OP_OR,  32'h0001_0000, 1'b1, 1'b1, 32'd16, 1'b0, 32'h0);
    run_op("and_ones",   0, 4, OP_AND, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0,  1'b0, 32'h0);
    run_op("and_fe",     0, 4, OP_AND, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd1,  1'b0, 32'h0);
    run_op("xor_7",      0, 4, OP_XOR, 32'h0000_0007, 1'b1, 1'b1, 32'd0,  1'b0, 32'h0);
    run_op("nor_zero",   0, 4, OP_NOR, 32'h0000_0000, 1'b1, 1'b0, 32'd0,  1'b0, 32'h0);
    run_op("nor_msb",    0, 4, OP_NOR, 32'h8000_0000, 1'b0, 1'b1, 32'd31, 1'b0, 32'h0);
    run_op("xor_ends",   0, 4, OP_XOR, 32'h8000_0001, 1'b0, 1'b1, 32'd0,  1'b0, 32'h0);
    run_op("or_zero",    0, 4, OP_OR,  32'h0000_0000, 1'b0, 1'b0, 32'd0,  1'b0, 32'h0);
    run_op("or_bit12",   0, 4, OP_OR,  32'h0000_F000, 1'b1, 1'b1, 32'd12, 1'b0, 32'h0);
    // start held through RUN and DONE, operand swapped mid-run
    run_op("hold_and",   0, 4, OP_AND, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0,  1'b1, 32'h0);
    run_op("hold_or",    0, 4, OP_OR,  32'h0000_0000, 1'b0, 1'b0, 32'd0,  1'b1, 32'hFFFF_FFFF);

    // N=10, C=4, K=3 with a padded last chunk
    run_op("p_and_ones", 1, 3, OP_AND, 32'h3FF, 1'b1, 1'b1, 32'd0, 1'b0, 32'h0);
    run_op("p_or_bit9",  1, 3, OP_OR,  32'h200, 1'b1, 1'b1, 32'd9, 1'b0, 32'h0);
    run_op("p_and_zero", 1, 3, OP_AND, 32'h000, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
    run_op("p_xor_201",  1, 3, OP_XOR, 32'h201, 1'b0, 1'b1, 32'd0, 1'b0, 32'h0);
    run_op("p_nor_bit8", 1, 3, OP_NOR, 32'h100, 1'b0, 1'b1, 32'd8, 1'b0, 32'h0);

    // N=C=4, K=1
    run_op("k1_or",      2, 1, OP_OR,  32'h4, 1'b1, 1'b1, 32'd2, 1'b0, 32'h0);
    run_op("k1_and",     2, 1, OP_AND, 32'h7, 1'b0, 1'b1, 32'd0, 1'b0, 32'h0);

    // reset in the middle of a fold
    sel = 0;
    drive(1'b1, OP_OR, 32'h0000_0001);
    @(posedge clk); #1;
    drive(1'b0, OP_OR, 32'h0000_0001);
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_rst/busy_pre", 32'(a_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst/state", 32'(a_state), 32'(S_IDLE));
    check("mid_rst/out", {a_if.busy, a_if.done, a_if.result, a_if.found, 27'(a_if.first_idx)}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst/no_done", 32'(a_if.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst/still_idle", 32'(a_if.busy | a_if.done), 32'd0);
    run_op("post_rst",   0, 4, OP_OR, 32'h0040_0000, 1'b1, 1'b1, 32'd22, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_reduce.md
# seq_reduce

Parametrised, multi-cycle bit-vector reduction engine: folds an N-bit operand C bits per clock under a selectable operator (OR, AND, XOR, NOR) and also reports the index of the lowest set bit. Generalises the fixed 32-bit OR chain into a width- and throughput-configurable unit with a start/busy/done handshake. It sits beside the datapath wherever a wide zero/any/parity test is needed and the single-cycle gate chain is too long for the clock period.

## Interface
- N, 32: operand width in bits; N >= 2.
- C, 8: chunk width folded per cycle; 1 <= C <= N.
- K (derived, localparam), ceil(N/C): number of fold cycles.
- IW (derived, localparam), $clog2(N): index width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operator: 00 OR, 01 AND, 10 XOR, 11 NOR; latched with start.
- in_data  in  N  operand; latched with start, may change afterwards.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when result is valid.
- result  out  1  reduction result; held until next accepted start.
- found  out  1  at least one bit of the latched operand is 1; held like result.
- first_idx  out  IW  index of lowest set bit; 0 when found = 0; held like result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start = 1 -> latch in_data, op; cnt <= 0; acc <= identity(op); found/first_idx scan state cleared; go RUN. start = 0 -> stay.
- RUN: each cycle fold chunk cnt (bits cnt*C .. cnt*C+C-1) into acc with op; cnt increments; at cnt = K-1 the fold completes and state -> DONE.
- DONE: done = 1 for exactly one cycle; result/found/first_idx registered; unconditionally -> IDLE. start in DONE is ignored.
- start while RUN or DONE: ignored, no queueing.
- Identity: 0 for OR/XOR/NOR, 1 for AND. Last chunk when N mod C != 0: missing bits padded with identity, never with X or stale data.
- NOR: fold as OR, invert once at completion.
- Lowest-set scan: on the first chunk containing a 1 (while found_int = 0), first_idx <= cnt*C + lowest set position in chunk, found_int <= 1; later chunks do not update it. Computed for every op.
- result, found, first_idx change only at the DONE-entering edge; they do not glitch during RUN.

## Timing
- start sampled at edge E0 -> busy high from E0 through EK; done high in the cycle following EK; latency from sampling edge to done = K+1 edges.
- Back-to-back: new start accepted earliest in the cycle after done (one idle cycle minimum); throughput one operation per K+2 cycles.
- C = N: K = 1, done two edges after start.
- Reset (any state, any time): state IDLE, busy = 0, done = 0, result = 0, found = 0, first_idx = 0, cnt = 0, acc = 0; an in-flight operation is discarded without a done pulse.

## Structure
- Package seq_reduce_pkg: op encodings (OP_OR, OP_AND, OP_XOR, OP_NOR), state enum, function returning identity for an op.
- Sub-module chunk_reduce: combinational fold of one C-bit chunk with incoming accumulator under op, plus any-set flag and lowest-set position within the chunk; instantiated once, reused every RUN cycle.
- Chunk select via indexed part-select of the latched operand after identity padding to K*C bits.

## Test plan
- N=32, C=8, op=OR, in_data=0x0001_0000 -> busy 4 cycles, done on 5th edge, result=1, found=1, first_idx=16.
- N=32, C=8, op=AND, in_data=0xFFFF_FFFF then 0xFFFF_FFFE -> result=1, then result=0; found=1, first_idx=0 and 1.
- N=32, C=8, op=XOR, in_data=0x0000_0007 -> result=1; op=NOR, in_data=0 -> result=1, found=0, first_idx=0.
- N=10, C=4 (K=3, padded last chunk), op=AND, in_data=10'h3FF -> result=1 (padding does not clear); op=OR, in_data=10'h200 -> first_idx=9.
- start reasserted during RUN and in DONE -> ignored, single done pulse, result from first operand; in_data changed mid-RUN -> no effect on result.
- rst_n pulled low at cnt=2 of a RUN -> outputs all 0 immediately, no done; next start after release completes normally with correct result.
